// File: rtl/warp_perf_counter_bank.sv
// Warp performance counter bank: live counters, shadow snapshot, record stream.
// Define PERF_SATURATE_EN to make event/cycle counters saturate instead of wrap.
module warp_perf_counter_bank #(
  parameter int NUM_WARPS      = 8,
  parameter int NUM_EVENTS     = 4,
  parameter int COUNTER_WIDTH  = 64,
  parameter int INTERVAL_WIDTH = 32,
  localparam int NREC = NUM_WARPS * NUM_EVENTS,
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int EW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
  localparam int CW = COUNTER_WIDTH,
  localparam int IW = INTERVAL_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREC-1:0] event_inc,
  input  logic [IW-1:0]   sample_interval,
  input  logic            sample_req,
  input  logic            clear_on_sample,
  input  logic            finished,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WW-1:0]   out_warp,
  output logic [EW-1:0]   out_event,
  output logic [CW-1:0]   out_count,
  output logic [CW-1:0]   out_cycle,
  output logic            out_last,
  output logic            out_final,
  output logic [15:0]     overrun_count,
  output logic            done
);

  localparam int KW = (NREC > 1) ? $clog2(NREC) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(NUM_WARPS - 1);
  localparam logic [EW-1:0] E_LAST = EW'(NUM_EVENTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] live_q   [NREC];
  logic [CW-1:0] shadow_q [NREC];
  logic [CW-1:0] cycle_q, stamp_q;
  logic [IW-1:0] ivl_q;
  logic [WW-1:0] warp_q;
  logic [EW-1:0] event_q;
  logic [KW-1:0] rec_idx;
  logic          final_q, pend_q, pend_d;
  logic          cnt_en, periodic, hs, last_rec;
  logic          take, take_fin, ovr;

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] v);
`ifdef PERF_SATURATE_EN
    return (&v) ? v : v + CW'(1);
`else
    return v + CW'(1);
`endif
  endfunction

  assign cnt_en   = enable && (state_q != S_DONE);
  assign periodic = cnt_en && (sample_interval != '0) &&
                    (ivl_q == sample_interval - IW'(1));
  assign hs       = (state_q == S_DRAIN) && out_ready;
  assign last_rec = (warp_q == W_LAST) && (event_q == E_LAST);
  assign rec_idx  = KW'(int'(warp_q) * NUM_EVENTS + int'(event_q));

  assign out_valid = (state_q == S_DRAIN);
  assign out_warp  = warp_q;
  assign out_event = event_q;
  assign out_count = shadow_q[rec_idx];
  assign out_cycle = stamp_q;
  assign out_last  = out_valid && last_rec;
  assign out_final = out_valid && final_q;
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    take     = 1'b0;
    take_fin = 1'b0;
    ovr      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sample_req || periodic || finished) begin
          take     = 1'b1;
          take_fin = finished;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        ovr = sample_req || periodic;
        if (finished && !final_q) pend_d = 1'b1;
        if (hs && last_rec) begin
          // a finish seen during a normal drain chains straight into the final one
          if (final_q) begin
            state_d = S_DONE;
          end else if (pend_q || finished) begin
            take     = 1'b1;
            take_fin = 1'b1;
            pend_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pend_q        <= 1'b0;
      final_q       <= 1'b0;
      overrun_count <= '0;
      cycle_q       <= '0;
      stamp_q       <= '0;
      ivl_q         <= '0;
      warp_q        <= '0;
      event_q       <= '0;
      for (int i = 0; i < NREC; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (ovr && (overrun_count != 16'hFFFF))
        overrun_count <= overrun_count + 16'd1;
      if (cnt_en) begin
        cycle_q <= bump(cycle_q);
        if (periodic || (sample_interval == '0)) ivl_q <= '0;
        else ivl_q <= ivl_q + IW'(1);
      end
      for (int i = 0; i < NREC; i++) begin
        if (take && clear_on_sample)
          live_q[i] <= CW'(cnt_en && event_inc[i]);
        else if (cnt_en && event_inc[i])
          live_q[i] <= bump(live_q[i]);
      end
      if (take) begin
        for (int i = 0; i < NREC; i++) shadow_q[i] <= live_q[i];
        stamp_q <= cycle_q;
        final_q <= take_fin;
        warp_q  <= '0;
        event_q <= '0;
      end else if (hs) begin
        if (event_q == E_LAST) begin
          event_q <= '0;
          warp_q  <= (warp_q == W_LAST) ? '0 : warp_q + WW'(1);
        end else begin
          event_q <= event_q + EW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_warp_perf_counter_bank.sv
// Bench for warp_perf_counter_bank: queue-based record model plus directed cases.
module tb_warp_perf_counter_bank;

  localparam int NW   = 4;
  localparam int NE   = 2;
  localparam int NR   = NW * NE;
  localparam int CW   = 6;
  localparam int IW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [NR-1:0] event_inc = '0;
  logic [IW-1:0] sample_interval = '0;
  logic          sample_req = 1'b0;
  logic          clear_on_sample = 1'b0;
  logic          finished = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_last, out_final, done;
  logic [1:0]    out_warp;
  logic [0:0]    out_event;
  logic [CW-1:0] out_count, out_cycle;
  logic [15:0]   overrun_count;

  warp_perf_counter_bank #(
    .NUM_WARPS(NW), .NUM_EVENTS(NE),
    .COUNTER_WIDTH(CW), .INTERVAL_WIDTH(IW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .event_inc(event_inc), .sample_interval(sample_interval),
    .sample_req(sample_req), .clear_on_sample(clear_on_sample),
    .finished(finished), .out_valid(out_valid), .out_ready(out_ready),
    .out_warp(out_warp), .out_event(out_event), .out_count(out_count),
    .out_cycle(out_cycle), .out_last(out_last), .out_final(out_final),
    .overrun_count(overrun_count), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int w;
    int e;
    int cnt;
    int cyc;
    bit last;
    bit fin;
  } rec_t;

  rec_t mq[$];
  rec_t mon_q[$];
  rec_t cap;
  bit   cap_v;
  int   m_live[NR];
  int   m_cyc, m_ivl, m_ovr;
  bit   m_pend, m_done;
  int   checks = 0;
  int   failures = 0;

  function automatic int bump(int v);
`ifdef PERF_SATURATE_EN
    return (v == MAXC) ? v : v + 1;
`else
    return (v + 1) % (MAXC + 1);
`endif
  endfunction

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < NR; k++) m_live[k] = 0;
    m_cyc = 0; m_ivl = 0; m_ovr = 0;
    m_pend = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit cen, per, busy, hs, take, fin, pend_now, inc;
    rec_t r;
    cen  = enable && !m_done;
    per  = cen && (sample_interval != 0) &&
           (m_ivl == int'(sample_interval) - 1);
    busy = mq.size() != 0;
    hs   = busy && out_ready;
    take = 0; fin = 0;
    if (!m_done && !busy && (sample_req || per || finished)) begin
      take = 1; fin = finished;
    end
    if (busy) begin
      if (sample_req || per) m_ovr = (m_ovr == 65535) ? m_ovr : m_ovr + 1;
      pend_now = m_pend || (finished && !mq[0].fin);
      m_pend = pend_now;
      if (hs && mq[0].last) begin
        if (mq[0].fin) m_done = 1;
        else if (pend_now) begin
          take = 1; fin = 1; m_pend = 0;
        end
      end
    end
    if (hs) mq.delete(0);
    if (take)
      for (int k = 0; k < NR; k++) begin
        r.w = k / NE; r.e = k % NE; r.cnt = m_live[k]; r.cyc = m_cyc;
        r.last = (k == NR - 1); r.fin = fin;
        mq.push_back(r);
      end
    for (int k = 0; k < NR; k++) begin
      inc = cen && event_inc[k];
      if (take && clear_on_sample) m_live[k] = inc ? 1 : 0;
      else if (inc) m_live[k] = bump(m_live[k]);
    end
    if (cen) begin
      m_cyc = bump(m_cyc);
      m_ivl = (per || sample_interval == 0) ? 0 : m_ivl + 1;
    end
  endtask

  task automatic model_cmp();
    bit ev, ok;
    ev = mq.size() != 0;
    ok = (out_valid === ev) && (int'(overrun_count) == m_ovr) &&
         (done === m_done);
    if (ev)
      ok = ok && int'(out_warp) == mq[0].w && int'(out_event) == mq[0].e &&
           int'(out_count) == mq[0].cnt && int'(out_cycle) == mq[0].cyc &&
           out_last === mq[0].last && out_final === mq[0].fin;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL model_cmp t=%0t actual v=%b ovr=%0d done=%b w=%0d e=%0d c=%0d cyc=%0d l=%b f=%b required v=%b ovr=%0d done=%b",
               $time, out_valid, overrun_count, done, out_warp, out_event,
               out_count, out_cycle, out_last, out_final, ev, m_ovr, m_done);
      if (ev)
        $display("  required rec w=%0d e=%0d c=%0d cyc=%0d l=%b f=%b",
                 mq[0].w, mq[0].e, mq[0].cnt, mq[0].cyc, mq[0].last, mq[0].fin);
    end
    cap_v = out_valid;
    cap.w = int'(out_warp); cap.e = int'(out_event);
    cap.cnt = int'(out_count); cap.cyc = int'(out_cycle);
    cap.last = out_last; cap.fin = out_final;
  endtask

  task automatic tick();
    @(posedge clock);
    if (cap_v && out_ready && !reset) mon_q.push_back(cap);
    if (reset) model_reset();
    else model_step();
    @(negedge clock);
    model_cmp();
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; event_inc = '0; sample_req = 0;
    finished = 0; out_ready = 0;
    tick(); tick();
    reset = 0;
    mon_q.delete();
  endtask

  int n;

  initial begin
    cap_v = 0;
    // reset state
    do_reset();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_warp", int'(out_warp), 0);
    chk("rst_event", int'(out_event), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_cycle", int'(out_cycle), 0);
    chk("rst_last_final", int'({out_last, out_final}), 0);
    chk("rst_overrun", int'(overrun_count), 0);
    chk("rst_done", int'(done), 0);

    // single on-demand snapshot
    out_ready = 1; enable = 1;
    event_inc = NR'(1 << 2);
    repeat (5) tick();
    event_inc = '0; sample_req = 1; tick(); sample_req = 0;
    repeat (10) tick();
    chk("t1_nrec", mon_q.size(), 8);
    if (mon_q.size() == 8) begin
      chk("t1_w10_cnt", mon_q[2].cnt, 5);
      chk("t1_w10_idx", mon_q[2].w * 10 + mon_q[2].e, 10);
      chk("t1_stamp", mon_q[2].cyc, 5);
      n = 0;
      for (int k = 0; k < 8; k++) if (k != 2) n += mon_q[k].cnt;
      chk("t1_others_zero", n, 0);
      n = 0;
      for (int k = 0; k < 8; k++) n += mon_q[k].last;
      chk("t1_last_once", n + (mon_q[7].last ? 10 : 0), 11);
    end

    // periodic sampling
    sample_interval = 10;
    do_reset();
    out_ready = 1; enable = 1;
    repeat (35) tick();
    n = 0;
    foreach (mon_q[k])
      if (mon_q[k].w == 0 && mon_q[k].e == 0) begin
        chk($sformatf("t2_stamp%0d", n), mon_q[k].cyc, 9 + 10 * n);
        n++;
      end
    chk("t2_nsnap", n, 3);
    chk("t2_overrun", int'(overrun_count), 0);
    sample_interval = 0;

    // overrun while stalled
    do_reset();
    enable = 1;
    event_inc = NR'(1);
    repeat (3) tick();
    event_inc = '0; sample_req = 1; tick(); sample_req = 0;
    tick();
    chk("t3_held_cnt0", int'(out_count), 3);
    for (int i = 0; i < 3; i++) begin
      sample_req = 1; tick(); sample_req = 0; tick();
    end
    chk("t3_overrun", int'(overrun_count), 3);
    chk("t3_held_cnt1", int'(out_count), 3);
    chk("t3_held_pos", int'({out_valid, out_warp, out_event}), 8);
    out_ready = 1;
    repeat (10) tick();
    chk("t3_nrec", mon_q.size(), 8);
    if (mon_q.size() > 0) chk("t3_rec0", mon_q[0].cnt, 3);

    // clear on sample with same-cycle strobe
    do_reset();
    clear_on_sample = 1; out_ready = 1; enable = 1;
    event_inc = NR'(1 << 5);
    repeat (7) tick();
    sample_req = 1; tick(); sample_req = 0; event_inc = '0;
    repeat (10) tick();
    sample_req = 1; tick(); sample_req = 0;
    repeat (10) tick();
    chk("t4_nrec", mon_q.size(), 16);
    if (mon_q.size() == 16) begin
      chk("t4_first", mon_q[5].cnt, 7);
      chk("t4_second", mon_q[13].cnt, 1);
    end
    clear_on_sample = 0;

    // finish mid-drain
    do_reset();
    out_ready = 1; enable = 1;
    event_inc = NR'(1);
    repeat (2) tick();
    event_inc = '0; sample_req = 1; tick(); sample_req = 0;
    repeat (3) tick();
    finished = 1; tick(); finished = 0;
    repeat (20) tick();
    chk("t5_done", int'(done), 1);
    chk("t5_nrec", mon_q.size(), 16);
    if (mon_q.size() == 16) begin
      n = 0;
      for (int k = 0; k < 16; k++) n += mon_q[k].fin ? (k >= 8 ? 1 : 100) : 0;
      chk("t5_final_flags", n, 8);
      chk("t5_final_cnt", mon_q[8].cnt, 2);
    end
    event_inc = '1; sample_req = 1;
    repeat (5) tick();
    event_inc = '0; sample_req = 0;
    chk("t5_no_more", mon_q.size(), 16);
    chk("t5_ovr_after", int'(overrun_count), 0);
    chk("t5_idle", int'({out_valid, done}), 1);

    // counter width overflow
    do_reset();
    out_ready = 1; enable = 1;
    event_inc = NR'(1 << 7);
    repeat (65) tick();
    event_inc = '0; sample_req = 1; tick(); sample_req = 0;
    repeat (10) tick();
    chk("t6_nrec", mon_q.size(), 8);
    if (mon_q.size() == 8) begin
`ifdef PERF_SATURATE_EN
      chk("t6_cnt", mon_q[7].cnt, 63);
      chk("t6_cyc", mon_q[7].cyc, 63);
`else
      chk("t6_cnt", mon_q[7].cnt, 1);
      chk("t6_cyc", mon_q[7].cyc, 1);
`endif
    end

    // randomized segments, each ended by a reset that may cut a drain
    for (int s = 0; s < 6; s++) begin
      sample_interval = ($urandom_range(0, 2) == 0) ? '0 :
                        IW'($urandom_range(4, 20));
      clear_on_sample = 1'($urandom_range(0, 1));
      do_reset();
      for (int c = 0; c < 600; c++) begin
        enable     = $urandom_range(0, 9) != 0;
        event_inc  = NR'($urandom) & NR'($urandom);
        sample_req = $urandom_range(0, 24) == 0;
        finished   = $urandom_range(0, 499) == 0;
        out_ready  = $urandom_range(0, 3) != 0;
        tick();
      end
    end
    reset = 1; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
